pipe_hazard_ctrl: RTL

//  Central pipeline control unit; drives the hold/flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers.
//  - Detects load-use hazards and inserts one bubble into ID/EX.
//  - Turns EX-stage jump requests into a redirect plus a flush of the younger stages.
//  - Freezes the whole pipe while a MEM-stage bus access waits for its ack.
//  - Flags a bus timeout and counts stall cycles.

---
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline hazard controller: load-use bubbles, jump redirects,
// bus-wait freezes with timeout detection, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_100MHz,
    input  logic             arst_n,
    input  logic [4:0]       id_reg1_r_addr_i,
    input  logic [4:0]       id_reg2_r_addr_i,
    input  logic             ex_mem_r_ena_i,
    input  logic [4:0]       ex_reg_w_addr_i,
    input  logic             ex_jump_req_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             hold_ex_mem_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             jump_ena_o,
    output logic [31:0]      jump_addr_o,
    output logic             bus_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT_C = WC_W'(TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use, mem_stall, advance;
    logic hold_all, jump_take, bubble, timeout_flag;

    assign load_use  = ex_mem_r_ena_i && (ex_reg_w_addr_i != 5'd0) &&
                       ((ex_reg_w_addr_i == id_reg1_r_addr_i) ||
                        (ex_reg_w_addr_i == id_reg2_r_addr_i));
    assign mem_stall = mem_req_i && !mem_ack_i;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        advance      = 1'b0;
        timeout_flag = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                // An ack releases the pipe even on the cycle the timeout would fire.
                if (mem_ack_i) begin
                    advance    = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q == TIMEOUT_C) state_d = ERR;
                end
            end
            default: begin
                timeout_flag = 1'b1;
            end
        endcase
    end

    // Jumps and bubbles only fire on cycles where the pipe actually advances,
    // so a jump held in EX during a bus wait is taken exactly once on the ack.
    assign hold_all  = !advance;
    assign jump_take = advance && ex_jump_req_i;
    assign bubble    = advance && !ex_jump_req_i && load_use;

    assign hold_pc_o     = arst_n && (hold_all || bubble);
    assign hold_if_id_o  = arst_n && (hold_all || bubble);
    assign hold_id_ex_o  = arst_n && hold_all;
    assign hold_ex_mem_o = arst_n && hold_all;
    assign flush_if_id_o = arst_n && jump_take;
    assign flush_id_ex_o = arst_n && (jump_take || bubble);
    assign jump_ena_o    = arst_n && jump_take;
    assign jump_addr_o   = (arst_n && jump_take) ? ex_jump_addr_i : 32'd0;
    assign bus_timeout_o = arst_n && timeout_flag;
    assign stall_cnt_o   = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((hold_all || bubble) && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
